fetch_control: RTL and testbench

- Consumer/controller side of the program-counter interface.
- Reads `pc` and fetches the instruction at that address over a req/ack memory handshake.
- Hands the instruction to execute with a valid/ready handshake, then drives `en_inc`, `st_flag` and `jmp_addr` back to the program counter.
- Resolves JMP/BRZ/BRN/HALT itself, so the program counter only sees one update pulse per retired instruction.

---
 rtl/fetch_control_pkg.sv | 23 ++
 rtl/fetch_control_branch_decode.sv | 34 +++
 rtl/fetch_control.sv | 128 ++++++++++++
 tb/tb_fetch_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_control_pkg.sv
// Shared opcode, field-position and state definitions for the fetch controller.
package fetch_pkg;

  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BRZ  = 4'hC;
  localparam logic [3:0] OP_BRN  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int TGT_HI = 15;
  localparam int TGT_LO = 0;

  typedef enum logic [2:0] {
    REQ_IDLE,
    FETCH,
    ISSUE,
    UPDATE,
    SETTLE,
    HALT
  } state_t;

endpackage

// File: rtl/fetch_control_branch_decode.sv
// Combinational branch resolution: opcode and ALU flags -> taken, halt, target.
module branch_decode
  import fetch_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] i_ir,
  input  logic               i_flagZ,
  input  logic               i_flagN,
  output logic               o_taken,
  output logic               o_isHalt,
  output logic [15:0]        o_target
);

  logic [3:0] w_opc;
  logic       w_unusedBits;

  assign w_opc        = i_ir[OPC_HI:OPC_LO];
  assign w_unusedBits = ^i_ir[OPC_LO-1:TGT_HI+1];

  always_comb begin
    o_taken = 1'b0;
    case (w_opc)
      OP_JMP:  o_taken = 1'b1;
      OP_BRZ:  o_taken = i_flagZ;
      OP_BRN:  o_taken = i_flagN;
      default: o_taken = 1'b0;
    endcase
  end

  assign o_isHalt = (w_opc == OP_HALT);
  assign o_target = i_ir[TGT_HI:TGT_LO];

endmodule

// File: rtl/fetch_control.sv
// Fetch/issue controller: fetches at pc, issues to execute, pulses one pc update per instruction.
// Optional fetch-ack timeout with sticky error when FETCH_TIMEOUT_EN is defined.
module fetch_control
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ex_ready,
  input  logic               flag_z,
  input  logic               flag_n,
  output logic               en_inc,
  output logic               st_flag,
  output logic [15:0]        jmp_addr,
  output logic               halted,
  input  logic               resume,
  output logic               fetch_err
);

  state_t             r_state;
  state_t             w_next;
  logic [INSTR_W-1:0] r_ir;
  logic               r_taken;
  logic [15:0]        r_target;
  logic               w_taken;
  logic               w_isHalt;
  logic [15:0]        w_target;
  logic               w_timeout;
  logic               w_unusedPc;

  assign w_unusedPc = ^pc[31:ADDR_W];

  branch_decode #(.INSTR_W(INSTR_W)) u_decode (
    .i_ir     (r_ir),
    .i_flagZ  (flag_z),
    .i_flagN  (flag_n),
    .o_taken  (w_taken),
    .o_isHalt (w_isHalt),
    .o_target (w_target)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == FETCH) && !imem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Counter sits at zero outside FETCH, so every FETCH entry starts a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != FETCH) r_cnt <= '0;
      else if (!imem_ack)   r_cnt <= r_cnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign fetch_err = r_err;
`else
  logic w_unusedCfg;

  assign w_unusedCfg = TIMEOUT[0];
  assign w_timeout   = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= REQ_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      REQ_IDLE: w_next = FETCH;
      FETCH: begin
        if (imem_ack)       w_next = ISSUE;
        else if (w_timeout) w_next = HALT;
      end
      ISSUE:    if (ex_ready) w_next = w_isHalt ? HALT : UPDATE;
      UPDATE:   w_next = SETTLE;
      SETTLE:   w_next = FETCH;
      HALT:     if (resume) w_next = UPDATE;
      default:  w_next = REQ_IDLE;
    endcase
  end

  // Branch outcome is frozen at the issue handshake; a resumed HALT always steps sequentially.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir     <= '0;
      r_taken  <= 1'b0;
      r_target <= '0;
    end else begin
      if (r_state == FETCH && imem_ack) r_ir <= imem_rdata;
      if (r_state == ISSUE && ex_ready) begin
        r_taken  <= w_taken;
        r_target <= w_target;
      end else if (r_state == HALT && resume) begin
        r_taken  <= 1'b0;
      end
    end
  end

  assign imem_req  = (r_state == FETCH);
  assign imem_addr = (r_state == FETCH) ? pc[ADDR_W-1:0] : '0;
  assign ir        = r_ir;
  assign ir_valid  = (r_state == ISSUE);
  assign en_inc    = (r_state == UPDATE);
  assign st_flag   = (r_state == UPDATE) && r_taken;
  assign jmp_addr  = ((r_state == UPDATE) && r_taken) ? r_target : 16'h0000;
  assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_fetch_control.sv
// Scoreboard bench for fetch_control: directed instructions, expected pc updates queued and checked by a monitor.
module tb_fetch_control;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ex_ready;
  logic        flag_z;
  logic        flag_n;
  logic        en_inc;
  logic        st_flag;
  logic [15:0] jmp_addr;
  logic        halted;
  logic        resume;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          lastReq = 0;
  logic [16:0] expQ[$];

  fetch_control dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ex_ready   (ex_ready),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .en_inc     (en_inc),
    .st_flag    (st_flag),
    .jmp_addr   (jmp_addr),
    .halted     (halted),
    .resume     (resume),
    .fetch_err  (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every pc update pulse must match the oldest queued expectation.
  initial begin : monitor
    logic        prevEn;
    logic [16:0] exp;
    prevEn = 1'b0;
    forever begin
      @(negedge clk);
      if (en_inc) begin
        checkOutput("en_inc_vs_req", {63'h0, imem_req}, 64'h0);
        checkOutput("en_inc_back_to_back", {63'h0, prevEn}, 64'h0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_en_inc: got st_flag=%0b jmp_addr=%0h expected no pulse", st_flag, jmp_addr);
        end else begin
          exp = expQ.pop_front();
          checkOutput("update", {47'h0, st_flag, jmp_addr}, {47'h0, exp});
        end
      end
      prevEn = en_inc;
    end
  end

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_wait: got no imem_req expected imem_req within 50 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pcVal, input logic [31:0] instr,
                               input logic z, input logic n, input int ackDelay,
                               input int readyDelay, input bit early,
                               input logic expSt, input logic [15:0] expJmp, input int expGap);
    bit ok;
    pc = pcVal;
    if (early) begin
      ex_ready = 1'b1;
      flag_z   = z;
      flag_n   = n;
    end
    waitReq(ok);
    if (!ok) return;
    if (expGap > 0) checkOutput("req_gap", 64'(cycle - lastReq), 64'(expGap));
    lastReq = cycle;
    checkOutput("imem_addr", {48'h0, imem_addr}, {48'h0, pcVal[15:0]});
    for (int k = 0; k < ackDelay; k++) begin
      @(negedge clk);
      checkOutput("req_held", {47'h0, imem_req, imem_addr}, {47'h0, 1'b1, pcVal[15:0]});
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h5A5A_5A5A;
    checkOutput("ir_load", {31'h0, ir_valid, ir}, {31'h0, 1'b1, instr});
    for (int k = 0; k < readyDelay; k++) begin
      @(negedge clk);
      checkOutput("ir_held", {31'h0, ir_valid, ir}, {31'h0, 1'b1, instr});
    end
    flag_z   = z;
    flag_n   = n;
    ex_ready = 1'b1;
    if (instr[31:28] != 4'hF) expQ.push_back({expSt, expJmp});
    @(negedge clk);
    ex_ready = 1'b0;
    flag_z   = 1'b0;
    flag_n   = 1'b0;
    checkOutput("ir_valid_drop", {63'h0, ir_valid}, 64'h0);
  endtask

  initial begin : main
    bit ok;
    rst        = 1'b0;
    pc         = 32'd5;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    ex_ready   = 1'b0;
    flag_z     = 1'b0;
    flag_n     = 1'b0;
    resume     = 1'b0;

    #12;
    checkOutput("reset_ir", {32'h0, ir}, 64'h0);
    checkOutput("reset_ctrl",
                {29'h0, ir_valid, en_inc, st_flag, jmp_addr, halted, imem_req, imem_addr, fetch_err},
                64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("req_idle_after_reset", {63'h0, imem_req}, 64'h0);

    applyStimulus(32'd5,         32'h1000_0000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000, 0);
    applyStimulus(32'd6,         32'hE000_0040, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 16'h0040, 4);
    applyStimulus(32'h40,        32'hC000_0020, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 16'h0020, 4);
    applyStimulus(32'h20,        32'hC000_0020, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 16'h0000, 4);
    applyStimulus(32'h0001_0021, 32'hD000_0123, 1'b0, 1'b1, 2, 3, 1'b0, 1'b1, 16'h0123, 0);
    applyStimulus(32'h123,       32'hD000_0123, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 16'h0000, 0);
    applyStimulus(32'h124,       32'hF000_0000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000, 0);

    checkOutput("halt_enter", {63'h0, halted}, 64'h1);
    for (int i = 0; i < 10; i++) begin
      imem_ack   = (i == 3);
      imem_rdata = 32'hE000_BEEF;
      @(negedge clk);
      checkOutput("halt_hold", {61'h0, halted, en_inc, imem_req}, {61'h0, 3'b100});
    end
    imem_ack = 1'b0;
    checkOutput("halt_ir_kept", {32'h0, ir}, {32'h0, 32'hF000_0000});

    expQ.push_back({1'b0, 16'h0000});
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    checkOutput("resume_clears_halted", {63'h0, halted}, 64'h0);

    resume = 1'b1;
    applyStimulus(32'h125, 32'h1000_0000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 16'h0000, 0);
    resume = 1'b0;

    pc = 32'h200;
    waitReq(ok);
    checkOutput("reset_fetch_addr", {48'h0, imem_addr}, 64'h200);
    rst      = 1'b0;
    imem_ack = 1'b1;
    #1;
    checkOutput("midfetch_reset_ctrl",
                {29'h0, ir_valid, en_inc, st_flag, jmp_addr, halted, imem_req, imem_addr, fetch_err},
                64'h0);
    checkOutput("midfetch_reset_ir", {32'h0, ir}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    rst      = 1'b1;
    applyStimulus(32'd7, 32'hE000_0333, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 16'h0333, 0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'h0);

`ifdef FETCH_TIMEOUT_EN
    pc = 32'd9;
    waitReq(ok);
    repeat (15) @(negedge clk);
    checkOutput("timeout_state", {61'h0, fetch_err, halted, imem_req}, {61'h0, 3'b110});
    expQ.push_back({1'b0, 16'h0000});
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    checkOutput("err_sticky_after_resume", {62'h0, fetch_err, halted}, {62'h0, 2'b10});
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained_err", 64'(expQ.size()), 64'h0);
`else
    checkOutput("fetch_err_tied", {63'h0, fetch_err}, 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
